// File: rtl/mac_pkg.sv
// Shared types and helpers for the sequential 4b multiply-accumulate block.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mac_state_t;

  typedef logic signed [3:0] q4_t;
  typedef logic signed [7:0] prod8_t;

  // Largest value representable in a signed accumulator of acc_w bits.
  function automatic longint sat_hi(input int acc_w);
    return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a signed accumulator of acc_w bits.
  function automatic longint sat_lo(input int acc_w);
    return -(64'sd1 <<< (acc_w - 1));
  endfunction

endpackage

// File: rtl/fa_1b.sv
// Gate-level full adder cell.
module fa_1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/ha_1b.sv
// Gate-level half adder cell.
module ha_1b (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);

  assign s  = a ^ b;
  assign co = a & b;

endmodule

// File: rtl/mul_2c_4b_full.sv
// Combinational signed 4x4 -> 8b multiplier (Baugh-Wooley), reduced column by
// column with ha_1b/fa_1b cells. Sign-row partial products are inverted and the
// correction constant 2^4 + 2^7 is folded into columns 4 and 7.
module mul_2c_4b_full
  import mac_pkg::*;
(
  input  q4_t    a,
  input  q4_t    b,
  output prod8_t p
);

  // pp[i][j] = a[i] & b[j], weight 2^(i+j)
  logic [3:0][3:0] pp;

  for (genvar i = 0; i < 4; i++) begin : g_pp
    assign pp[i] = {4{a[i]}} & b;
  end

  // Inverted sign-row terms
  logic n03, n13, n23, n30, n31, n32;
  assign n03 = ~pp[0][3];
  assign n13 = ~pp[1][3];
  assign n23 = ~pp[2][3];
  assign n30 = ~pp[3][0];
  assign n31 = ~pp[3][1];
  assign n32 = ~pp[3][2];

  logic s1, k1;
  logic s2a, k2a, s2, k2b;
  logic s3a, k3a, s3b, k3b, s3, k3c;
  logic s4a, k4a, s4b, k4b, s4, k4c;
  logic s5a, k5a, s5, k5b;
  logic s6, k6;

  // Column 1
  ha_1b u_c1  (.a(pp[0][1]), .b(pp[1][0]), .s(s1), .co(k1));
  // Column 2
  fa_1b u_c2a (.a(pp[0][2]), .b(pp[1][1]), .ci(pp[2][0]), .s(s2a), .co(k2a));
  ha_1b u_c2b (.a(s2a), .b(k1), .s(s2), .co(k2b));
  // Column 3
  fa_1b u_c3a (.a(n03), .b(pp[1][2]), .ci(pp[2][1]), .s(s3a), .co(k3a));
  fa_1b u_c3b (.a(n30), .b(k2a), .ci(k2b), .s(s3b), .co(k3b));
  ha_1b u_c3c (.a(s3a), .b(s3b), .s(s3), .co(k3c));
  // Column 4 (includes correction bit 2^4)
  fa_1b u_c4a (.a(n13), .b(pp[2][2]), .ci(n31), .s(s4a), .co(k4a));
  fa_1b u_c4b (.a(k3a), .b(k3b), .ci(k3c), .s(s4b), .co(k4b));
  fa_1b u_c4c (.a(s4a), .b(s4b), .ci(1'b1), .s(s4), .co(k4c));
  // Column 5
  fa_1b u_c5a (.a(n23), .b(n32), .ci(k4a), .s(s5a), .co(k5a));
  fa_1b u_c5b (.a(s5a), .b(k4b), .ci(k4c), .s(s5), .co(k5b));
  // Column 6
  fa_1b u_c6  (.a(pp[3][3]), .b(k5a), .ci(k5b), .s(s6), .co(k6));

  // Column 7 holds the correction bit 2^7 plus k6; the carry out is mod 2^8.
  assign p = prod8_t'({~k6, s6, s5, s4, s3, s2, s1, pp[0][0]});

endmodule

// File: rtl/mac_seq_4b.sv
// Sequential signed dot-product engine: one 4x4 multiplier, a registered
// product stage and a saturating accumulator, framed by start/len and a
// valid/ready result handshake.
module mac_seq_4b
  import mac_pkg::*;
#(
  parameter int N_MAX = 16,
  parameter int ACC_W = 12,
  parameter int LEN_W = $clog2(N_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  q4_t                     x_in,
  input  q4_t                     w_in,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [ACC_W-1:0] res_data,
  output logic                    res_ovf
);

  localparam logic [LEN_W-1:0]        LEN_MAX = LEN_W'(N_MAX);
  localparam logic signed [ACC_W:0]   SAT_HI  = (ACC_W + 1)'(sat_hi(ACC_W));
  localparam logic signed [ACC_W:0]   SAT_LO  = (ACC_W + 1)'(sat_lo(ACC_W));

  mac_state_t               state, state_nx;
  logic [LEN_W-1:0]         len_q, cnt, len_eff;
  logic signed [ACC_W-1:0]  acc, acc_sat;
  logic signed [ACC_W:0]    acc_sum;
  logic                     ovf, sat_hit;
  prod8_t                   prod, p_q;
  logic                     p_v;
  logic                     hs, last_pair;

  mul_2c_4b_full u_mul (
    .a (x_in),
    .b (w_in),
    .p (prod)
  );

  assign len_eff   = (len > LEN_MAX) ? LEN_MAX : len;
  assign in_ready  = (state == RUN) && (cnt < len_q);
  assign hs        = in_valid && in_ready;
  assign last_pair = hs && (cnt == len_q - LEN_W'(1));

  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);
  assign res_data  = acc;
  assign res_ovf   = ovf;

  // Saturating add of the pending product into the accumulator.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    acc_sum = {acc[ACC_W-1], acc} + {{(ACC_W - 7){p_q[7]}}, p_q};
    acc_sat = acc_sum[ACC_W-1:0];
    sat_hit = 1'b0;
    if (acc_sum > SAT_HI) begin
      acc_sat = SAT_HI[ACC_W-1:0];
      sat_hit = 1'b1;
    end else if (acc_sum < SAT_LO) begin
      acc_sat = SAT_LO[ACC_W-1:0];
      sat_hit = 1'b1;
    end
  end

  // Next-state logic for the IDLE -> RUN -> DRAIN -> DONE sequence.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = (len == '0) ? DONE : RUN;
      RUN:     if (last_pair) state_nx = DRAIN;
      DRAIN:   state_nx = DONE;
      DONE:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Datapath: pair counter, product register and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      cnt   <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
      p_q   <= '0;
      p_v   <= 1'b0;
    end else if (state == IDLE && start) begin
      len_q <= len_eff;
      cnt   <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
      p_v   <= 1'b0;
    end else begin
      if (p_v) begin
        acc <= acc_sat;
        if (sat_hit) ovf <= 1'b1;
      end
      p_v <= hs;
      if (hs) begin
        p_q <= prod;
        cnt <= cnt + LEN_W'(1);
      end
    end
  end

endmodule
